fsm_launcher: RTL
=================

# fsm_launcher

Controller-side counterpart of the basic run/done worker FSM. It accepts a batch request of N jobs and issues one single-cycle `out_run` pulse per job to a worker. It then waits for the worker's `in_done` before issuing the next job. It counts completions, guards each job with a timeout watchdog, and reports batch completion or timeout to the upstream logic.

## Interface
- `CNT_W`, default 8: width of job count and completion counter.
- `TIMEOUT`, default 16: maximum number of WAIT cycles per job before abort. Legal range is 2 to 2^16.
- `TMR_W`, default 16: width of the watchdog timer. Must hold TIMEOUT-1.

Ports:
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `in_start`, input, 1: batch request. Sampled only in IDLE.
- `in_num`, input, CNT_W: number of jobs in the batch. Sampled together with `in_start`.
- `in_done`, input, 1: worker completion. Sampled only in WAIT.
- `out_run`, output, 1: run pulse to worker. High exactly in ISSUE.
- `out_busy`, output, 1: high in every state except IDLE.
- `out_finish`, output, 1: one-cycle pulse when a batch completes (FINISH state).
- `out_timeout`, output, 1: one-cycle pulse when a job times out (ERROR state).
- `out_count`, output, CNT_W: number of jobs completed in the current or last batch.

## Operation
- States: IDLE, ISSUE, WAIT, FINISH, ERROR. Use a 3-bit encoding; unused codes go to IDLE.
- Structure: a registered state process, a combinational next-state process, and Moore outputs decoded from the current state. `out_count` is a register.

Transitions:
- IDLE, `in_start`=1, `in_num`≠0: latch `in_num` into `num_r`, clear `out_count`, go to ISSUE.
- IDLE, `in_start`=1, `in_num`=0: clear `out_count`, go to FINISH. No `out_run` is issued.
- IDLE, `in_start`=0: stay in IDLE. `out_count` holds its value.
- ISSUE: always go to WAIT after one cycle. Clear the timer.
- WAIT, `in_done`=1: increment `out_count`. If the incremented value equals `num_r`, go to FINISH; otherwise go to ISSUE.
- WAIT, `in_done`=0, timer = TIMEOUT-1: go to ERROR. `out_count` is not incremented.
- WAIT, `in_done`=0, otherwise: increment the timer and stay in WAIT.
- FINISH: go to IDLE. ERROR: go to IDLE.

Boundary behaviour:
- `in_done` in IDLE, ISSUE, FINISH or ERROR is ignored. This includes a stale `in_done` arriving in the same cycle as `out_run`.
- `in_start` outside IDLE is ignored. It is not queued.
- `in_done` in the last allowed WAIT cycle (timer = TIMEOUT-1) counts as completion. Completion has priority over timeout.
- `in_num` = 2^CNT_W-1: `out_count` reaches the maximum value with no wrap.
- `num_r` is frozen for the whole batch. Changes on `in_num` after start have no effect.
- ERROR leaves `out_count` at the number of jobs completed before the failure, until the next accepted start.

Reset:
- On `rst_n` low, state becomes IDLE, timer, `num_r` and `out_count` become 0, and all outputs become 0, immediately and asynchronously.
- Reset mid-batch aborts without any `out_finish` or `out_timeout` pulse.

## Timing
- Every output is 0 during reset and in IDLE, except that `out_count` holds its last value in IDLE.
- `in_start` is sampled at edge E0. `out_run` is high for the cycle after E0 and `out_busy` rises in that same cycle.
- Per job: 1 ISSUE cycle, then k WAIT cycles, where the k-th cycle has `in_done`=1 (1 ≤ k ≤ TIMEOUT).
- The next `out_run` follows the done cycle directly, one cycle after it.
- `out_finish` is high for the one cycle after the final accepted `in_done`. `out_busy` drops the cycle after that.
- For N jobs with worker latency k: `out_finish` occurs N·(k+1)+1 cycles after E0.
- With `in_num`=0: `out_finish` occurs in the cycle immediately after E0, with `out_run` never asserted.
- Timeout: `out_timeout` is high in the cycle after the TIMEOUT-th consecutive WAIT cycle with `in_done`=0.
- Back-to-back batches: a new `in_start` is accepted at the first IDLE cycle, which is one cycle after FINISH or ERROR.

## Test plan
- Reset then idle: hold `rst_n`=0 with random inputs, then release with `in_start`=0 for 10 cycles. Required: `out_run`, `out_busy`, `out_finish`, `out_timeout` and `out_count` stay 0.
- Batch of 3: `in_num`=3, `in_start` pulse, worker responds with `in_done` 2 cycles after each `out_run`. Required: exactly 3 `out_run` pulses spaced 3 cycles apart, `out_count` steps 1→2→3, and one `out_finish` pulse 10 cycles after the start edge.
- Zero jobs: `in_num`=0 with `in_start`. Required: `out_finish` in the next cycle, no `out_run`, `out_count`=0.
- Timeout: `in_num`=2, worker answers job 1 only. Required: `out_count`=1, and `out_timeout` pulses exactly TIMEOUT+1 cycles after the second `out_run`. Also drive `in_done` exactly at WAIT cycle 16. Required: counted as completion, no timeout.
- Ignored inputs: `in_start` with `in_num`=9 while busy in a 2-job batch, plus `in_done` asserted during ISSUE. Required: batch ends with `out_count`=2, with no extra `out_run` and no early count.
- Mid-batch reset: assert `rst_n`=0 during WAIT of job 2 of 4. Required: all outputs go to 0 immediately, with no `out_finish` or `out_timeout`. A fresh 1-job batch then completes normally.

Source files
------------

// File: rtl/fsm_launcher.sv
// Batch launcher: issues one out_run pulse per job, waits for in_done with a
// per-job watchdog, counts completions and reports finish or timeout.
module fsm_launcher #(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 16,
    parameter int TMR_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_start,
    input  logic [CNT_W-1:0] in_num,
    input  logic             in_done,
    output logic             out_run,
    output logic             out_busy,
    output logic             out_finish,
    output logic             out_timeout,
    output logic [CNT_W-1:0] out_count,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        WAIT   = 3'd2,
        FINISH = 3'd3,
        ERROR  = 3'd4
    } state_t;

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    state_t           state;
    state_t           state_nxt;
    logic [TMR_W-1:0] timer;
    logic [CNT_W-1:0] num_r;
    logic [CNT_W-1:0] count_inc;

    // Worker handshake: out_run is a one-cycle request; the worker answers with
    // in_done, which is only honoured while waiting, so stale pulses are dropped.
    assign count_inc = out_count + 1'b1;

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE: begin
                if (in_start) begin
                    state_nxt = (in_num != '0) ? ISSUE : FINISH;
                end else begin
                    state_nxt = IDLE;
                end
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                if (in_done) begin
                    state_nxt = (count_inc == num_r) ? FINISH : ISSUE;
                end else if (timer == TMR_LAST) begin
                    state_nxt = ERROR;
                end else begin
                    state_nxt = WAIT;
                end
            end
            FINISH:  state_nxt = IDLE;
            ERROR:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Completion takes priority over the watchdog in the last WAIT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer     <= '0;
            num_r     <= '0;
            out_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_start) begin
                        out_count <= '0;
                        if (in_num != '0) begin
                            num_r <= in_num;
                        end
                    end
                end
                ISSUE: timer <= '0;
                WAIT: begin
                    if (in_done) begin
                        out_count <= count_inc;
                    end else if (timer != TMR_LAST) begin
                        timer <= timer + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_run     = (state == ISSUE);
    assign out_busy    = (state != IDLE);
    assign out_finish  = (state == FINISH);
    assign out_timeout = (state == ERROR);
    assign dbg_state   = state;

endmodule
